// File: rtl/cycle_sequencer_if.sv
// Purpose: control/handshake bundle between the multi-cycle sequencer and its datapath/memory.
// Latency: pure wiring, no storage.
// Backpressure: memReady is the only stall input; request strobes stay high until it arrives.
// Ports (master = sequencer view):
//   in : opcode[6:0], memReady, branchTaken
//   out: state[2:0], instrFetch, memRead, memWrite, irWrite, regWrite, pcWrite, pcTarget,
//        retire, instret[31:0], halted, illegal, busError
interface cycle_sequencer_if;
    logic [6:0]  opcode;
    logic        memReady;
    logic        branchTaken;
    logic [2:0]  state;
    logic        instrFetch;
    logic        memRead;
    logic        memWrite;
    logic        irWrite;
    logic        regWrite;
    logic        pcWrite;
    logic        pcTarget;
    logic        retire;
    logic [31:0] instret;
    logic        halted;
    logic        illegal;
    logic        busError;

    modport master (
        input  opcode, memReady, branchTaken,
        output state, instrFetch, memRead, memWrite, irWrite, regWrite,
               pcWrite, pcTarget, retire, instret, halted, illegal, busError
    );

    modport slave (
        output opcode, memReady, branchTaken,
        input  state, instrFetch, memRead, memWrite, irWrite, regWrite,
               pcWrite, pcTarget, retire, instret, halted, illegal, busError
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Purpose: multi-cycle RV32 control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT).
// Latency: FENCE 2, BRANCH 3, STORE 4, others 4-5 cycles plus memory wait cycles.
// Backpressure: FETCH/MEMORY hold their request until memReady; optional timeout halts with busError.
// Ports: clk, rst (sync, active-high); bus = cycle_sequencer_if.master (see interface header).
module cycle_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    cycle_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
        C_LOAD, C_STORE, C_OPIMM, C_OP, C_FENCE, C_SYSTEM
    } cls_t;

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        curState, nextState;
    cls_t          decCls, clsQ;
    logic [CW-1:0] waitCnt;
    logic [31:0]   instretQ;
    logic          haltedQ, illegalQ, busErrorQ;
    logic          timeoutHit, setIllegal, setBusError;

    always_comb begin
        decCls = C_ILLEGAL;
        case (bus.opcode)
            7'b0110111: decCls = C_LUI;
            7'b0010111: decCls = C_AUIPC;
            7'b1101111: decCls = C_JAL;
            7'b1100111: decCls = C_JALR;
            7'b1100011: decCls = C_BRANCH;
            7'b0000011: decCls = C_LOAD;
            7'b0100011: decCls = C_STORE;
            7'b0010011: decCls = C_OPIMM;
            7'b0110011: decCls = C_OP;
            7'b0001111: decCls = C_FENCE;
            7'b1110011: decCls = C_SYSTEM;
            default:    decCls = C_ILLEGAL;
        endcase
    end

    // Acknowledge in the expiry cycle wins because memReady is tested before timeoutHit.
    assign timeoutHit = (MEM_TIMEOUT > 0) && (waitCnt == TO_LAST) && !bus.memReady;

    always_comb begin
        nextState      = curState;
        setIllegal     = 1'b0;
        setBusError    = 1'b0;
        bus.instrFetch = 1'b0;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.irWrite    = 1'b0;
        bus.regWrite   = 1'b0;
        bus.pcWrite    = 1'b0;
        bus.pcTarget   = 1'b0;
        bus.retire     = 1'b0;
        case (curState)
            S_FETCH: begin
                bus.instrFetch = 1'b1;
                bus.memRead    = 1'b1;
                if (bus.memReady) begin
                    bus.irWrite = 1'b1;
                    nextState   = S_DECODE;
                end else if (timeoutHit) begin
                    nextState   = S_HALT;
                    setBusError = 1'b1;
                end
            end
            // DECODE uses the live opcode; the class is captured for later states.
            S_DECODE: begin
                case (decCls)
                    C_ILLEGAL: begin
                        nextState  = S_HALT;
                        setIllegal = 1'b1;
                    end
                    C_SYSTEM:  nextState = S_HALT;
                    C_FENCE: begin
                        bus.pcWrite = 1'b1;
                        bus.retire  = 1'b1;
                        nextState   = S_FETCH;
                    end
                    default:   nextState = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                case (clsQ)
                    C_LOAD, C_STORE: nextState = S_MEMORY;
                    C_BRANCH: begin
                        bus.pcWrite  = 1'b1;
                        bus.pcTarget = bus.branchTaken;
                        bus.retire   = 1'b1;
                        nextState    = S_FETCH;
                    end
                    default:         nextState = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                bus.memRead  = (clsQ == C_LOAD);
                bus.memWrite = (clsQ == C_STORE);
                if (bus.memReady) begin
                    if (clsQ == C_LOAD) begin
                        nextState = S_WRITEBACK;
                    end else begin
                        bus.pcWrite = 1'b1;
                        bus.retire  = 1'b1;
                        nextState   = S_FETCH;
                    end
                end else if (timeoutHit) begin
                    nextState   = S_HALT;
                    setBusError = 1'b1;
                end
            end
            S_WRITEBACK: begin
                bus.regWrite = 1'b1;
                bus.pcWrite  = 1'b1;
                bus.pcTarget = (clsQ == C_JAL) || (clsQ == C_JALR);
                bus.retire   = 1'b1;
                nextState    = S_FETCH;
            end
            S_HALT:  nextState = S_HALT;
            default: nextState = S_HALT;
        endcase
        // Reset silences every strobe immediately, before the edge takes effect.
        if (rst) begin
            bus.instrFetch = 1'b0;
            bus.memRead    = 1'b0;
            bus.memWrite   = 1'b0;
            bus.irWrite    = 1'b0;
            bus.regWrite   = 1'b0;
            bus.pcWrite    = 1'b0;
            bus.pcTarget   = 1'b0;
            bus.retire     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            curState  <= S_FETCH;
            clsQ      <= C_ILLEGAL;
            waitCnt   <= '0;
            instretQ  <= '0;
            haltedQ   <= 1'b0;
            illegalQ  <= 1'b0;
            busErrorQ <= 1'b0;
        end else begin
            curState <= nextState;
            if (curState == S_DECODE) begin
                clsQ <= decCls;
            end
            // Any state change clears the counter, so it starts at zero on entry to FETCH/MEMORY.
            if (nextState != curState) begin
                waitCnt <= '0;
            end else if (((curState == S_FETCH) || (curState == S_MEMORY)) && !bus.memReady) begin
                waitCnt <= waitCnt + CW'(1);
            end
            instretQ  <= instretQ + 32'(bus.retire);
            haltedQ   <= haltedQ | (nextState == S_HALT);
            illegalQ  <= illegalQ | setIllegal;
            busErrorQ <= busErrorQ | setBusError;
        end
    end

    assign bus.state    = curState;
    assign bus.instret  = instretQ;
    assign bus.halted   = haltedQ;
    assign bus.illegal  = illegalQ;
    assign bus.busError = busErrorQ;
endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;
    localparam int TO = 4;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int K_ILL = 0, K_LUI = 1, K_AUIPC = 2, K_JAL = 3, K_JALR = 4, K_BR = 5,
                   K_LD = 6, K_ST = 7, K_OPI = 8, K_OP = 9, K_FENCE = 10, K_SYS = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cycle_sequencer_if ifc ();
    cycle_sequencer #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int          tests = 0;
    int          fails = 0;
    logic [31:0] expRet = '0;
    bit          expHalted = 1'b0, expIll = 1'b0, expBus = 1'b0;
    logic [6:0]  legalOps [11];

    function automatic int classOf(input logic [6:0] op);
        case (op)
            OP_LUI:    return K_LUI;
            OP_AUIPC:  return K_AUIPC;
            OP_JAL:    return K_JAL;
            OP_JALR:   return K_JALR;
            OP_BRANCH: return K_BR;
            OP_LOAD:   return K_LD;
            OP_STORE:  return K_ST;
            OP_OPIMM:  return K_OPI;
            OP_OP:     return K_OP;
            OP_FENCE:  return K_FENCE;
            OP_SYSTEM: return K_SYS;
            default:   return K_ILL;
        endcase
    endfunction

    // Expected {state, instrFetch, memRead, memWrite, irWrite, regWrite, pcWrite, pcTarget, retire}.
    function automatic logic [10:0] ev(input int st, input bit iF, input bit mR, input bit mW,
                                       input bit ir, input bit rw, input bit pw, input bit pt,
                                       input bit rt);
        logic [2:0] s;
        s = st[2:0];
        return {s, iF, mR, mW, ir, rw, pw, pt, rt};
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic cyc(input logic [6:0] op, input logic rdy, input logic bt,
                       input logic [10:0] expv, input string tag);
        logic [13:0] obs, want;
        ifc.opcode      = op;
        ifc.memReady    = rdy;
        ifc.branchTaken = bt;
        @(negedge clk);
        obs  = {ifc.state, ifc.instrFetch, ifc.memRead, ifc.memWrite, ifc.irWrite, ifc.regWrite,
                ifc.pcWrite, ifc.pcTarget, ifc.retire, ifc.halted, ifc.illegal, ifc.busError};
        want = {expv, expHalted, expIll, expBus};
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, want);
        end
        tests++;
        assert (ifc.instret === expRet) else begin
            fails++;
            $error("FAIL %s instret observed=%0d expected=%0d", tag, ifc.instret, expRet);
        end
        @(posedge clk);
        #1;
        if (expv[0]) expRet = expRet + 32'd1;
    endtask

    task automatic doHalt(input bit ill, input bit busErr, input string tag);
        expHalted = 1'b1;
        expIll    = expIll | ill;
        expBus    = expBus | busErr;
        repeat (10) cyc(rop(), rbit(), rbit(), ev(5, 0, 0, 0, 0, 0, 0, 0, 0), tag);
    endtask

    // One cycle with rst high (memReady high too, so FETCH would otherwise request).
    task automatic doReset(input int st, input string tag);
        rst = 1'b1;
        cyc(rop(), 1'b1, rbit(), ev(st, 0, 0, 0, 0, 0, 0, 0, 0), tag);
        rst       = 1'b0;
        expRet    = '0;
        expHalted = 1'b0;
        expIll    = 1'b0;
        expBus    = 1'b0;
    endtask

    // Reference: each instruction expands into its phase sequence with the given wait counts.
    task automatic runInstr(input logic [6:0] op, input int fw, input int mw, input bit bt,
                            input string tag);
        int k;
        bit isLd;
        k    = classOf(op);
        isLd = (k == K_LD);
        if (TO > 0 && fw >= TO) begin
            repeat (TO) cyc(rop(), 1'b0, rbit(), ev(0, 1, 1, 0, 0, 0, 0, 0, 0), tag);
            doHalt(0, 1, tag);
            doReset(5, tag);
            return;
        end
        repeat (fw) cyc(rop(), 1'b0, rbit(), ev(0, 1, 1, 0, 0, 0, 0, 0, 0), tag);
        cyc(rop(), 1'b1, rbit(), ev(0, 1, 1, 0, 1, 0, 0, 0, 0), tag);
        if (k == K_ILL || k == K_SYS) begin
            cyc(op, rbit(), rbit(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0), tag);
            doHalt(k == K_ILL, 0, tag);
            doReset(5, tag);
            return;
        end
        if (k == K_FENCE) begin
            cyc(op, rbit(), rbit(), ev(1, 0, 0, 0, 0, 0, 1, 0, 1), tag);
            return;
        end
        cyc(op, rbit(), rbit(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0), tag);
        if (k == K_BR) begin
            cyc(rop(), rbit(), bt, ev(2, 0, 0, 0, 0, 0, 1, bt, 1), tag);
            return;
        end
        cyc(rop(), rbit(), bt, ev(2, 0, 0, 0, 0, 0, 0, 0, 0), tag);
        if (k == K_LD || k == K_ST) begin
            if (TO > 0 && mw >= TO) begin
                repeat (TO) cyc(rop(), 1'b0, rbit(), ev(3, 0, isLd, !isLd, 0, 0, 0, 0, 0), tag);
                doHalt(0, 1, tag);
                doReset(5, tag);
                return;
            end
            repeat (mw) cyc(rop(), 1'b0, rbit(), ev(3, 0, isLd, !isLd, 0, 0, 0, 0, 0), tag);
            cyc(rop(), 1'b1, rbit(), ev(3, 0, isLd, !isLd, 0, 0, !isLd, 0, !isLd), tag);
            if (!isLd) return;
        end
        cyc(rop(), rbit(), rbit(), ev(4, 0, 0, 0, 0, 1, 1, (k == K_JAL || k == K_JALR), 1), tag);
    endtask

    initial begin
        legalOps = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                     OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM};
        ifc.opcode      = '0;
        ifc.memReady    = 1'b0;
        ifc.branchTaken = 1'b0;
        @(posedge clk);
        #1;
        doReset(0, "por");

        runInstr(OP_OPIMM, 0, 0, 0, "opimm");
        runInstr(OP_LOAD, 0, 3, 0, "load_wait3");
        runInstr(OP_BRANCH, 0, 0, 1, "branch_taken");
        runInstr(OP_BRANCH, 1, 0, 0, "branch_not");
        runInstr(OP_JAL, 0, 0, 0, "jal");
        runInstr(OP_JALR, 2, 0, 0, "jalr");
        runInstr(OP_STORE, 0, 1, 0, "store");
        runInstr(OP_FENCE, 0, 0, 0, "fence");
        runInstr(OP_LUI, 0, 0, 0, "lui");
        runInstr(7'b0000000, 0, 0, 0, "illegal");
        runInstr(OP_SYSTEM, 0, 0, 0, "system");
        runInstr(OP_OPIMM, 4, 0, 0, "fetch_timeout");
        runInstr(OP_OPIMM, 3, 0, 0, "fetch_ready_at_expiry");
        runInstr(OP_LOAD, 3, 3, 0, "mem_counter_restart");
        runInstr(OP_STORE, 0, 4, 0, "mem_timeout");

        // Reset in the middle of a STORE wait.
        runInstr(OP_FENCE, 0, 0, 0, "abort_pre");
        cyc(rop(), 1'b1, rbit(), ev(0, 1, 1, 0, 1, 0, 0, 0, 0), "abort_fetch");
        cyc(OP_STORE, rbit(), rbit(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0), "abort_decode");
        cyc(rop(), rbit(), rbit(), ev(2, 0, 0, 0, 0, 0, 0, 0, 0), "abort_exec");
        cyc(rop(), 1'b0, rbit(), ev(3, 0, 0, 1, 0, 0, 0, 0, 0), "abort_memwait");
        doReset(3, "abort_rst");
        cyc(rop(), 1'b0, rbit(), ev(0, 1, 1, 0, 0, 0, 0, 0, 0), "abort_after");

        for (int n = 0; n < 80; n++) begin
            int sel, r, fw, mw;
            logic [6:0] op;
            sel = $urandom_range(0, 13);
            op  = (sel < 11) ? legalOps[sel] : rop();
            r   = $urandom_range(0, 9);
            fw  = (r < 7) ? (r % 3) : (3 + r % 3);
            r   = $urandom_range(0, 9);
            mw  = (r < 7) ? (r % 3) : (3 + r % 3);
            runInstr(op, fw, mw, rbit(), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
